// File: rtl/ldpc_adder_gf2_pkg.sv
// Shared types for the GF(2) accumulate arbiter: FSM states and the result record.
package ldpc_adder_gf2_pkg;

  // Result fields are sized for the largest supported configuration.
  // Narrower instances leave the high bits at constant zero.
  localparam int RES_DATA_MAX = 64;
  localparam int RES_ID_MAX   = 4;
  localparam int RES_CNT_MAX  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_OUTPUT
  } state_t;

  typedef struct packed {
    logic [RES_DATA_MAX-1:0] data;
    logic [RES_ID_MAX-1:0]   id;
    logic [RES_CNT_MAX-1:0]  count;
    logic                    trunc;
  } result_t;

endpackage

// File: rtl/ldpc_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, with wrap-around.
module ldpc_rr_arbiter
  import ldpc_adder_gf2_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  logic [ID_W:0]   cand;
  logic [ID_W-1:0] cand_idx;

  // One extra bit on cand keeps ptr+i from overflowing before the modulo wrap.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      cand_idx = cand[ID_W-1:0];
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/ldpc_adder_gf2_arb.sv
// Shares one GF(2) XOR accumulator among NUM_REQ packet streams; the grant is held for a
// whole packet and one tagged parity word is emitted per packet through valid/ready.
module ldpc_adder_gf2_arb
  import ldpc_adder_gf2_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4,
  parameter int MAX_OPS = 64,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = $clog2(MAX_OPS + 1)
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ-1:0]       i_req_last,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic [WIDTH-1:0]         o_out_data,
  output logic [ID_W-1:0]          o_out_id,
  output logic [CNT_W-1:0]         o_out_count,
  output logic                     o_out_trunc,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic                     o_busy
);

  state_t               state_q, state_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]   grant_oh_q, grant_oh_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     count_q, count_d;
  result_t              res_q, res_d;
  logic                 out_valid_q, out_valid_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [ID_W-1:0]      arb_idx;
  logic                 arb_any;

  logic [WIDTH-1:0]     sel_data;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 beat;
  logic [CNT_W-1:0]     count_inc;
  logic                 hit_max;
  logic [WIDTH-1:0]     acc_next;

  ldpc_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arbiter (
    .req       (i_req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_comb begin
    sel_data = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant_q == ID_W'(r)) begin
        sel_data = i_req_data[r*WIDTH +: WIDTH];
      end
    end
  end

  assign sel_valid   = i_req_valid[grant_q];
  assign sel_last    = i_req_last[grant_q];
  assign o_req_ready = (state_q == ST_ACCUM) ? grant_oh_q : '0;
  assign beat        = sel_valid && (state_q == ST_ACCUM);
  assign count_inc   = count_q + 1'b1;
  assign hit_max     = (count_inc == CNT_W'(MAX_OPS));
  assign acc_next    = acc_q ^ sel_data;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_oh_d  = grant_oh_q;
    rr_ptr_d    = rr_ptr_q;
    acc_d       = acc_q;
    count_d     = count_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d    = arb_idx;
          grant_oh_d = arb_grant;
          acc_d      = '0;
          count_d    = '0;
          state_d    = ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        if (beat) begin
          acc_d   = acc_next;
          count_d = count_inc;
          if (sel_last || hit_max) begin
            res_d.data  = RES_DATA_MAX'(acc_next);
            res_d.id    = RES_ID_MAX'(grant_q);
            res_d.count = RES_CNT_MAX'(count_inc);
            res_d.trunc = hit_max && !sel_last;
            out_valid_d = 1'b1;
            state_d     = ST_OUTPUT;
          end
        end
      end

      ST_OUTPUT: begin
        if (i_out_ready) begin
          out_valid_d = 1'b0;
          rr_ptr_d    = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      grant_oh_q  <= '0;
      rr_ptr_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_oh_q  <= grant_oh_d;
      rr_ptr_q    <= rr_ptr_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign o_out_data  = res_q.data[WIDTH-1:0];
  assign o_out_id    = res_q.id[ID_W-1:0];
  assign o_out_count = res_q.count[CNT_W-1:0];
  assign o_out_trunc = res_q.trunc;
  assign o_out_valid = out_valid_q;
  assign o_busy      = (state_q != ST_IDLE);

  logic unused_res_hi;
  assign unused_res_hi = ^{res_q.data, res_q.id, res_q.count};

endmodule
